and_gate: RTL and testbench
===========================

AND_GATE -- requirements
Module: and_gate

Interface
REQ-001 Parameter WIDTH, default 1: bit width of A, B, Y and y_q.
REQ-002 Parameter CNT_W, default 16: width of hi_count.
REQ-003 Port clk  input  1: single clock; all sequential logic on rising edge.
REQ-004 Port rst_n  input  1: reset; asynchronous, active-low.
REQ-005 Port A  input  WIDTH: operand A.
REQ-006 Port B  input  WIDTH: operand B.
REQ-007 Port clr  input  1: synchronous clear of hi_count, active-high.
REQ-008 Port Y  output  WIDTH: combinational bitwise AND of A and B.
REQ-009 Port y_q  output  WIDTH: Y registered on clk.
REQ-010 Port y_all  output  1: combinational reduction-AND of Y (all bits high).
REQ-011 Port y_rise  output  1: one-cycle pulse on y_all rising edge.
REQ-012 Port y_fall  output  1: one-cycle pulse on y_all falling edge.
REQ-013 Port hi_count  output  CNT_W: saturating count of clock edges sampling y_all=1.

Function
REQ-014 Y SHALL equal A & B bitwise, purely combinational, zero latency, independent of clk and rst_n.
REQ-015 Y SHALL settle in the same timestep as any A/B change; a sample at the next posedge SHALL show the new value.
REQ-016 y_all SHALL equal reduction-AND of Y; for WIDTH=1, y_all == Y.
REQ-017 y_q SHALL load Y on every rising clk edge; latency exactly 1 cycle.
REQ-018 An internal register y_all_d SHALL hold y_all from the previous edge.
REQ-019 y_rise SHALL be registered: 1 for the cycle after an edge where y_all=1 and y_all_d=0, else 0.
REQ-020 y_fall SHALL be registered: 1 for the cycle after an edge where y_all=0 and y_all_d=1, else 0.
REQ-021 hi_count SHALL increment by 1 on each edge sampling y_all=1; holds otherwise.
REQ-022 hi_count SHALL saturate at 2^CNT_W-1; no wrap-around.
REQ-023 clr=1 at an edge SHALL set hi_count to 0, taking priority over increment in the same cycle.
REQ-024 X/Z on A or B SHALL propagate per standard AND semantics (0 & X = 0); no masking.

Reset
REQ-025 rst_n=0 SHALL asynchronously force y_q=0, y_all_d=0, y_rise=0, y_fall=0, hi_count=0.
REQ-026 Y and y_all SHALL be unaffected by reset.
REQ-027 First edge after rst_n deasserts SHALL operate normally; y_all=1 there produces y_rise=1 (since y_all_d=0).
REQ-028 Reset asserted mid-operation SHALL clear all registers immediately, without waiting for clk.

Structure
REQ-029 A shared package and_gate_pkg SHALL hold default WIDTH and CNT_W constants and the saturation-max helper constant.
REQ-030 One sub-module, and_gate_edge_cnt (edge detector plus saturating counter), SHALL be instantiated; the AND datapath and y_q register stay in the top.
REQ-031 No latches; combinational logic via continuous assignment or always_comb.

Verification
REQ-032 WIDTH=1, rst_n=1; apply A,B = 00,01,10,11, one per clock period, sampling at each posedge -> Y = 0,0,0,1.
REQ-033 Same sequence -> y_q = 0,0,0,1 delayed one cycle behind Y; y_rise=1 for exactly one cycle after the 11 edge; hi_count increments to 1.
REQ-034 Hold A=B=1 for 5 edges then set A=0 -> hi_count=5, y_fall=1 for one cycle, y_rise not repeated.
REQ-035 CNT_W=3, hold A=B=1 for 10 edges -> hi_count stops at 7; clr=1 with y_all=1 -> hi_count=0 next cycle.
REQ-036 Pull rst_n low between edges while y_q=1, hi_count=4 -> both 0 immediately; Y still tracks A&B during reset.
REQ-037 WIDTH=4, A=4'b1011, B=4'b1110 -> Y=4'b1010, y_all=0; A=B=4'hF -> y_all=1.

Source files
------------

// File: rtl/and_gate_pkg.sv
// Shared constants for the and_gate slice.
// Default widths and the saturating counter limit helper.
package and_gate_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 16;

  function automatic logic [63:0] cnt_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  localparam logic [DEF_CNT_W-1:0] DEF_CNT_MAX =
    DEF_CNT_W'(cnt_max(DEF_CNT_W));

endpackage

// File: rtl/and_gate_edge_cnt.sv
// Edge detector on y_all plus a saturating count
// of clock edges that sample y_all high.
module and_gate_edge_cnt
  import and_gate_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             y_all,
  output logic             y_rise,
  output logic             y_fall,
  output logic [CNT_W-1:0] hi_count
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(cnt_max(CNT_W));

  logic y_all_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_all_d  <= 1'b0;
      y_rise   <= 1'b0;
      y_fall   <= 1'b0;
      hi_count <= '0;
    end else begin
      y_all_d <= y_all;
      y_rise  <= y_all & ~y_all_d;
      y_fall  <= ~y_all & y_all_d;
      // clear wins over counting in the same cycle
      if (clr)
        hi_count <= '0;
      else if (y_all && hi_count != CNT_MAX)
        hi_count <= hi_count + 1'b1;
    end
  end

endmodule

// File: rtl/and_gate.sv
// Bitwise AND datapath with registered copy,
// all-ones flag and edge/count monitor.
module and_gate
  import and_gate_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             clr,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_all,
  output logic             y_rise,
  output logic             y_fall,
  output logic [CNT_W-1:0] hi_count
);

  assign Y     = A & B;
  assign y_all = &Y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      y_q <= '0;
    else
      y_q <= Y;
  end

  and_gate_edge_cnt #(
    .CNT_W(CNT_W)
  ) u_edge_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .y_all   (y_all),
    .y_rise  (y_rise),
    .y_fall  (y_fall),
    .hi_count(hi_count)
  );

endmodule

// File: tb/tb_and_gate.sv
// Randomized and directed bench for and_gate in
// three configurations against a behavioural model.
module tb_and_gate;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // u1: WIDTH=1 CNT_W=16
  logic a1, b1, clr1, y1, yq1, all1, r1, f1;
  logic [15:0] c1;
  // u3: WIDTH=1 CNT_W=3
  logic a3, b3, clr3, y3, yq3, all3, r3, f3;
  logic [2:0] c3;
  // u4: WIDTH=4 CNT_W=4
  logic [3:0] a4, b4, y4, yq4;
  logic clr4, all4, r4, f4;
  logic [3:0] c4;

  and_gate #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .clr(clr1),
    .Y(y1), .y_q(yq1), .y_all(all1), .y_rise(r1),
    .y_fall(f1), .hi_count(c1));

  and_gate #(.WIDTH(1), .CNT_W(3)) u3 (
    .clk(clk), .rst_n(rst_n), .A(a3), .B(b3), .clr(clr3),
    .Y(y3), .y_q(yq3), .y_all(all3), .y_rise(r3),
    .y_fall(f3), .hi_count(c3));

  and_gate #(.WIDTH(4), .CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .clr(clr4),
    .Y(y4), .y_q(yq4), .y_all(all4), .y_rise(r4),
    .y_fall(f4), .hi_count(c4));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // model: count of high samples, previous level, pulses
  int         m_cnt [3];
  bit         m_prev[3];
  bit         m_rise[3];
  bit         m_fall[3];
  logic [3:0] m_yq  [3];
  int         m_max [3] = '{65535, 7, 15};

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_prev[i] = 0;
      m_rise[i] = 0; m_fall[i] = 0; m_yq[i] = 0;
    end
  endtask

  task automatic m_upd(input int i, input logic [3:0] y,
                       input bit all, input bit c);
    m_rise[i] = all && !m_prev[i];
    m_fall[i] = !all && m_prev[i];
    m_prev[i] = all;
    m_yq[i]   = y;
    if (c) m_cnt[i] = 0;
    else if (all && m_cnt[i] < m_max[i]) m_cnt[i]++;
  endtask

  task automatic model_edge();
    if (!rst_n) m_reset();
    else begin
      m_upd(0, {3'b0, a1 & b1}, a1 & b1, clr1);
      m_upd(1, {3'b0, a3 & b3}, a3 & b3, clr3);
      m_upd(2, a4 & b4, (a4 & b4) == 4'hF, clr4);
    end
  endtask

  task automatic check_comb();
    chk("u1.Y", 32'(y1), 32'(a1 & b1));
    chk("u1.y_all", 32'(all1), 32'(a1 & b1));
    chk("u3.Y", 32'(y3), 32'(a3 & b3));
    chk("u4.Y", 32'(y4), 32'(a4 & b4));
    chk("u4.y_all", 32'(all4), 32'((a4 & b4) == 4'hF));
  endtask

  task automatic check_all();
    check_comb();
    chk("u1.y_q", 32'(yq1), 32'(m_yq[0]));
    chk("u1.rise", 32'(r1), 32'(m_rise[0]));
    chk("u1.fall", 32'(f1), 32'(m_fall[0]));
    chk("u1.cnt", 32'(c1), 32'(m_cnt[0]));
    chk("u3.y_q", 32'(yq3), 32'(m_yq[1]));
    chk("u3.rise", 32'(r3), 32'(m_rise[1]));
    chk("u3.fall", 32'(f3), 32'(m_fall[1]));
    chk("u3.cnt", 32'(c3), 32'(m_cnt[1]));
    chk("u4.y_q", 32'(yq4), 32'(m_yq[2]));
    chk("u4.rise", 32'(r4), 32'(m_rise[2]));
    chk("u4.fall", 32'(f4), 32'(m_fall[2]));
    chk("u4.cnt", 32'(c4), 32'(m_cnt[2]));
  endtask

  // inputs only change at negedge, so the posedge sees them stable
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    a1 = 0; b1 = 0; clr1 = 0;
    a3 = 0; b3 = 0; clr3 = 0;
    a4 = 0; b4 = 0; clr4 = 0;
    m_reset();
    tick();
    chk("rst.u1.cnt", 32'(c1), 32'd0);
    chk("rst.u1.y_q", 32'(yq1), 32'd0);
    rst_n = 1'b1;

    // 00,01,10,11 one per cycle
    for (int k = 0; k < 4; k++) begin
      a1 = k[1]; b1 = k[0];
      #1 check_comb();
      tick();
    end
    chk("seq.Y11", 32'(y1), 32'd1);
    chk("seq.yq11", 32'(yq1), 32'd1);
    chk("seq.rise", 32'(r1), 32'd1);
    chk("seq.cnt1", 32'(c1), 32'd1);

    // hold 11 for five edges in total, then drop A
    repeat (4) tick();
    chk("hold.rise0", 32'(r1), 32'd0);
    a1 = 0;
    tick();
    chk("hold.cnt5", 32'(c1), 32'd5);
    chk("hold.fall", 32'(f1), 32'd1);
    chk("hold.norise", 32'(r1), 32'd0);
    tick();
    chk("hold.fall1cyc", 32'(f1), 32'd0);

    // saturation with CNT_W=3
    a3 = 1; b3 = 1;
    repeat (10) tick();
    chk("sat.cnt7", 32'(c3), 32'd7);
    clr3 = 1;
    tick();
    chk("sat.clr", 32'(c3), 32'd0);
    clr3 = 0; a3 = 0;

    // WIDTH=4 patterns
    a4 = 4'b1011; b4 = 4'b1110;
    #1 chk("w4.Y", 32'(y4), 32'hA);
    chk("w4.all0", 32'(all4), 32'd0);
    a4 = 4'hF; b4 = 4'hF;
    #1 chk("w4.all1", 32'(all4), 32'd1);
    tick();

    // build y_q=1, hi_count=4 on u1 then reset between edges
    a1 = 1; b1 = 1; clr1 = 1;
    tick();
    clr1 = 0;
    repeat (4) tick();
    chk("pre.cnt4", 32'(c1), 32'd4);
    chk("pre.yq1", 32'(yq1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst.yq", 32'(yq1), 32'd0);
    chk("arst.cnt", 32'(c1), 32'd0);
    chk("arst.Y", 32'(y1), 32'd1);
    a1 = 0;
    #1 chk("arst.Ytrack", 32'(y1), 32'd0);
    a1 = 1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post.rise", 32'(r1), 32'd1);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      a1 = 1'($urandom); b1 = 1'($urandom);
      a3 = ($urandom_range(0, 3) != 0);
      b3 = ($urandom_range(0, 3) != 0);
      a4 = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
      b4 = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
      clr1 = ($urandom_range(0, 15) == 0);
      clr3 = ($urandom_range(0, 15) == 0);
      clr4 = ($urandom_range(0, 15) == 0);
      #1 check_comb();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
